// File: rtl/pwm_multi_pkg.sv
// Shared constants for the multi-channel PWM peripheral: register map and duty/counter widths.
package pwm_multi_pkg;

  localparam int unsigned ADDR_OUT_EN    = 0;
  localparam int unsigned ADDR_PWM_EN    = 1;
  localparam int unsigned ADDR_PRESCALE  = 2;
  localparam int unsigned ADDR_POLARITY  = 3;
  localparam int unsigned ADDR_DUTY_BASE = 4;

  localparam int unsigned DUTY_W = 8;
  localparam logic [DUTY_W-1:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: shadow duty register, loaded on the period wrap, plus the compare against
// the shared period counter. A shadow of 0xFF means "always high" with no dip at cnt=255.
module pwm_channel_cmp
  import pwm_multi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DUTY_W-1:0] duty_stage,
  input  logic [DUTY_W-1:0] cnt,
  output logic              wave
);

  logic [DUTY_W-1:0] shadow_q;

  // Shadow duty takes the staged value only on the wrap strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (load) begin
      shadow_q <= duty_stage;
    end
  end

  // Compare, with full-scale duty forced high.
  always_comb begin
    wave = (shadow_q == CNT_MAX) ? 1'b1 : (cnt < shadow_q);
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM peripheral: register file, shared prescaler, 8-bit period counter,
// per-channel compare units and a registered read port.
// Optional output polarity register at address 0x3 when PWM_MULTI_POLARITY_EN is defined;
// otherwise that address is unmapped and no XOR stage exists.
module pwm_multi_channel
  import pwm_multi_pkg::*;
#(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned PRESCALE_W = 8,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  localparam logic [ADDR_W-1:0] A_OUT_EN   = ADDR_W'(ADDR_OUT_EN);
  localparam logic [ADDR_W-1:0] A_PWM_EN   = ADDR_W'(ADDR_PWM_EN);
  localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(ADDR_PRESCALE);

  logic [NUM_CH-1:0]     out_en_q;
  logic [NUM_CH-1:0]     pwm_en_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [DUTY_W-1:0]     duty_stage_q [NUM_CH];
  logic [PRESCALE_W-1:0] div_q;
  logic [DUTY_W-1:0]     cnt_q;

  logic                  we_out_en;
  logic                  we_pwm_en;
  logic                  we_prescale;
  logic [NUM_CH-1:0]     we_duty;
  logic                  tick;
  logic                  wrap;
  logic [NUM_CH-1:0]     wave;
  logic [NUM_CH-1:0]     pwm_d;
  logic [7:0]            rd_d;

`ifdef PWM_MULTI_POLARITY_EN
  localparam logic [ADDR_W-1:0] A_POLARITY = ADDR_W'(ADDR_POLARITY);
  logic [NUM_CH-1:0] polarity_q;
  logic              we_polarity;

  // Polarity decode and register.
  always_comb begin
    we_polarity = wr_en && (wr_addr == A_POLARITY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      polarity_q <= '0;
    end else if (we_polarity) begin
      polarity_q <= wr_data[NUM_CH-1:0];
    end
  end
`endif

  // Write address decode.
  always_comb begin
    we_out_en   = wr_en && (wr_addr == A_OUT_EN);
    we_pwm_en   = wr_en && (wr_addr == A_PWM_EN);
    we_prescale = wr_en && (wr_addr == A_PRESCALE);
    we_duty     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      we_duty[i] = wr_en && (wr_addr == ADDR_W'(ADDR_DUTY_BASE + i));
    end
  end

  // Register file; mask bits above NUM_CH are simply not stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en_q   <= '0;
      pwm_en_q   <= '0;
      prescale_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_stage_q[i] <= '0;
      end
    end else begin
      if (we_out_en)   out_en_q   <= wr_data[NUM_CH-1:0];
      if (we_pwm_en)   pwm_en_q   <= wr_data[NUM_CH-1:0];
      if (we_prescale) prescale_q <= PRESCALE_W'(wr_data);
      for (int i = 0; i < NUM_CH; i++) begin
        if (we_duty[i]) duty_stage_q[i] <= wr_data;
      end
    end
  end

  // Tick and wrap strobes.
  always_comb begin
    tick = (div_q == prescale_q);
    wrap = tick && (cnt_q == CNT_MAX);
  end

  // Prescaler: a prescale write restarts the divider so new spacing applies at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (we_prescale || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Period counter and wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      period_start <= 1'b0;
    end else begin
      if (tick) cnt_q <= cnt_q + 1'b1;
      period_start <= wrap;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    pwm_channel_cmp u_cmp (
      .clk        (clk),
      .rst        (rst),
      .load       (wrap),
      .duty_stage (duty_stage_q[g]),
      .cnt        (cnt_q),
      .wave       (wave[g])
    );
  end

  // Output gating: disabled channel low, enabled non-PWM channel static high.
  always_comb begin
    pwm_d = out_en_q & (~pwm_en_q | wave);
`ifdef PWM_MULTI_POLARITY_EN
    pwm_d = pwm_d ^ polarity_q;
`endif
  end

  // Read mux; unmapped addresses read 0.
  always_comb begin
    rd_d = '0;
    if (rd_addr == A_OUT_EN)   rd_d = 8'(out_en_q);
    if (rd_addr == A_PWM_EN)   rd_d = 8'(pwm_en_q);
    if (rd_addr == A_PRESCALE) rd_d = 8'(prescale_q);
`ifdef PWM_MULTI_POLARITY_EN
    if (rd_addr == A_POLARITY) rd_d = 8'(polarity_q);
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == ADDR_W'(ADDR_DUTY_BASE + i)) rd_d = duty_stage_q[i];
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
      rd_data <= '0;
    end else begin
      pwm_out <= pwm_d;
      rd_data <= rd_d;
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel (NUM_CH=8): register table, directed waveform measurements,
// and randomized traffic against a cycle-level reference model.
module tb_pwm_multi_channel;

`ifdef PWM_MULTI_POLARITY_EN
  localparam bit POL = 1'b1;
`else
  localparam bit POL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] pwm_out;
  logic       period_start;

  pwm_multi_channel #(
    .NUM_CH     (8),
    .PRESCALE_W (8),
    .ADDR_W     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_out_en, m_pwm_en, m_pol;
  int         m_prescale, m_div, m_ticks;
  int         m_stage  [8];
  int         m_shadow [8];
  logic [7:0] exp_pwm, exp_rd;
  logic       exp_ps;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (a == 0) return m_out_en;
    if (a == 1) return m_pwm_en;
    if (a == 2) return 8'(m_prescale);
    if (a == 3) return POL ? m_pol : 8'h00;
    if (a >= 4 && a < 12) return 8'(m_stage[a-4]);
    return 8'h00;
  endfunction

  // Advance the model by one clk edge using the inputs currently applied.
  task automatic model_edge();
    int cnt;
    bit tick, w, b;
    if (rst) begin
      m_out_en = 0; m_pwm_en = 0; m_pol = 0;
      m_prescale = 0; m_div = 0; m_ticks = 0;
      for (int i = 0; i < 8; i++) begin
        m_stage[i] = 0;
        m_shadow[i] = 0;
      end
      exp_pwm = 0; exp_rd = 0; exp_ps = 0;
      return;
    end
    cnt  = m_ticks % 256;
    tick = (m_div == m_prescale);
    exp_rd = m_read(rd_addr);
    for (int i = 0; i < 8; i++) begin
      w = (m_shadow[i] == 255) ? 1'b1 : (cnt < m_shadow[i]);
      b = m_out_en[i] & (m_pwm_en[i] ? w : 1'b1);
      if (POL) b = b ^ m_pol[i];
      exp_pwm[i] = b;
    end
    exp_ps = tick && (cnt == 255);
    if (tick) begin
      if (cnt == 255) for (int i = 0; i < 8; i++) m_shadow[i] = m_stage[i];
      m_ticks++;
      m_div = 0;
    end else begin
      m_div++;
    end
    if (wr_en) begin
      if (wr_addr == 0) m_out_en = wr_data;
      if (wr_addr == 1) m_pwm_en = wr_data;
      if (wr_addr == 2) begin
        m_prescale = int'(wr_data);
        m_div = 0;
      end
      if (wr_addr == 3 && POL) m_pol = wr_data;
      if (wr_addr >= 4 && wr_addr < 12) m_stage[wr_addr-4] = int'(wr_data);
    end
  endtask

  // One clock: model step, edge, then compare every output against the model.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check("pwm_out", int'(pwm_out), int'(exp_pwm));
    check("period_start", int'(period_start), int'(exp_ps));
    check("rd_data", int'(rd_data), int'(exp_rd));
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_ps(input int limit, input string name);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!period_start && n < limit);
    check(name, int'(period_start), 1);
  endtask

  // Starting in a period_start cycle, count high cycles over len clocks.
  task automatic measure(input int len, output int h0, output int h1, output int h2,
                         output int ps);
    h0 = 0; h1 = 0; h2 = 0; ps = 0;
    for (int k = 0; k < len; k++) begin
      cyc();
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
      ps += int'(period_start);
    end
  endtask

  typedef struct {
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] ra;
    logic [7:0] er;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int h0, h1, h2, ps, n;
    tbl[0] = '{4'h0, 8'hA5, 4'h0, 8'hA5};
    tbl[1] = '{4'h1, 8'h3C, 4'h1, 8'h3C};
    tbl[2] = '{4'h2, 8'h07, 4'h2, 8'h07};
    tbl[3] = '{4'h4, 8'h11, 4'h4, 8'h11};
    tbl[4] = '{4'hB, 8'hEE, 4'hB, 8'hEE};
    tbl[5] = '{4'hC, 8'h55, 4'hC, 8'h00};
    tbl[6] = '{4'hF, 8'h00, 4'hF, 8'h00};
    tbl[7] = '{4'h3, 8'h01, 4'h3, POL ? 8'h01 : 8'h00};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    cyc();
    rst = 1'b0;

    // Register table
    for (int t = 0; t < 8; t++) begin
      wr(tbl[t].wa, tbl[t].wd);
      rd_addr = tbl[t].ra;
      cyc();
      check("tbl_readback", int'(rd_data), int'(tbl[t].er));
    end

    // Reset with registers non-zero
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_period_start", int'(period_start), 0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      cyc();
      check("rst_reg_zero", int'(rd_data), 0);
    end

    // Basic waveform and duty boundaries, prescale 0
    wr(4'h2, 8'h00);
    wr(4'h0, 8'h07);
    wr(4'h1, 8'h07);
    wr(4'h4, 8'h40);
    wr(4'h5, 8'h00);
    wr(4'h6, 8'hFF);
    wait_ps(600, "first_wrap");
    for (int p = 0; p < 3; p++) begin
      measure(256, h0, h1, h2, ps);
      check("duty40_high", h0, 64);
      check("duty00_high", h1, 0);
      check("dutyFF_high", h2, 256);
      check("period256_ps", ps, 1);
      check("period256_end", int'(period_start), 1);
    end

    // Double buffer: mid-period write keeps current period
    h0 = 0;
    for (int k = 0; k < 256; k++) begin
      if (k == 100) wr(4'h4, 8'h80);
      else cyc();
      h0 += int'(pwm_out[0]);
    end
    check("dbuf_cur_period", h0, 64);
    measure(256, h0, h1, h2, ps);
    check("dbuf_next_period", h0, 128);

    // Write on the exact wrap cycle: shadow gets the old staged value
    repeat (255) cyc();
    wr(4'h4, 8'h20);
    check("wrap_write_ps", int'(period_start), 1);
    measure(256, h0, h1, h2, ps);
    check("wrap_write_old", h0, 128);
    measure(256, h0, h1, h2, ps);
    check("wrap_write_new", h0, 32);

    // Prescale 3
    wr(4'h2, 8'h03);
    wr(4'h4, 8'h10);
    wait_ps(2000, "ps3_wrap");
    wait_ps(1100, "ps3_wrap2");
    measure(1024, h0, h1, h2, ps);
    check("ps3_high", h0, 64);
    check("ps3_ps_count", ps, 1);
    check("ps3_period_end", int'(period_start), 1);

    // Mid-period prescale change restarts the divider
    repeat (10) cyc();
    wr(4'h2, 8'h01);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!period_start && n < 2000);
    check("prescale_change_len", n, 508);

    // Static mode
    wr(4'h0, 8'hFF);
    wr(4'h1, 8'h00);
    cyc();
    check("static_all_ones", int'(pwm_out), 8'hFF);

    // Unmapped address
    wr(4'hF, 8'h00);
    rd_addr = 4'hF;
    cyc();
    check("unmapped_read", int'(rd_data), 0);
    rd_addr = 4'h0;
    cyc();
    check("unmapped_no_effect", int'(rd_data), 8'hFF);

    // Polarity (ch0 disabled)
    wr(4'h0, 8'hFE);
    wr(4'h3, 8'h01);
    cyc();
    check("polarity_out", int'(pwm_out), POL ? 8'hFF : 8'hFE);
    rd_addr = 4'h3;
    cyc();
    check("polarity_read", int'(rd_data), POL ? 1 : 0);
    wr(4'h3, 8'h00);

    // Randomized traffic against the model
    wr(4'h2, 8'h00);
    for (int k = 0; k < 5000; k++) begin
      rst     = ($urandom_range(0, 799) == 0);
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 8'($urandom);
      if (wr_addr == 4'h2) wr_data = 8'($urandom_range(0, 2));
      rd_addr = 4'($urandom_range(0, 15));
      cyc();
    end
    rst = 1'b0; wr_en = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
